priority_arbiter_rr: RTL

//  Registered N-way arbiter; sequential successor to the combinational priority encoder.

---
 rtl/priority_arbiter_rr_if.sv | 32 +++
 rtl/priority_arbiter_rr.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_rr_if.sv
// Request/grant bundle between requesters and the registered arbiter.
// The timeout pulse only exists when ARB_TIMEOUT_EN is defined.
interface priority_arbiter_rr_if #(
   parameter int NUM_REQ  = 8,
   parameter int IDX_BITS = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]  req;
   logic                rr_mode;
   logic                done;
   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_BITS-1:0] gnt_idx;
   logic                gnt_valid;
`ifdef ARB_TIMEOUT_EN
   logic                timeout;
`endif

   modport master (
      output req, rr_mode, done,
      input  gnt, gnt_idx, gnt_valid
`ifdef ARB_TIMEOUT_EN
      , input timeout
`endif
   );

   modport slave (
      input  req, rr_mode, done,
      output gnt, gnt_idx, gnt_valid
`ifdef ARB_TIMEOUT_EN
      , output timeout
`endif
   );
endinterface

// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter, fixed-priority or round-robin, holding a grant until release.
// Define ARB_TIMEOUT_EN to add a hold counter that force-releases after TIMEOUT cycles.
module priority_arbiter_rr #(
   parameter int NUM_REQ  = 8,
   parameter int IDX_BITS = $clog2(NUM_REQ)
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT  = 64,
   parameter int TO_BITS  = $clog2(TIMEOUT + 1)
`endif
) (
   input logic                  clk,
   input logic                  rst_n,
   priority_arbiter_rr_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic [IDX_BITS-1:0] ptr_q, ptr_d;
`ifdef ARB_TIMEOUT_EN
   logic [TO_BITS-1:0]  cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
   logic                hold_expired;
`endif

   logic [NUM_REQ-1:0]  cand;
   logic [IDX_BITS-1:0] win_idx;
   logic [IDX_BITS-1:0] rr_pos;
   logic                win_found;
   logic                release_evt;

   // The current owner never competes in the arbitration that releases it.
   assign cand = bus.req & ~gnt_q;

`ifdef ARB_TIMEOUT_EN
   assign hold_expired = (cnt_q == TO_BITS'(TIMEOUT - 1));
   assign release_evt  = bus.done | ~bus.req[idx_q] | hold_expired;
`else
   assign release_evt  = bus.done | ~bus.req[idx_q];
`endif

   // Later loop iterations overwrite earlier ones, so the last hit is the winner.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      rr_pos    = '0;
      if (!bus.rr_mode) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cand[i]) begin
               win_idx   = IDX_BITS'(i);
               win_found = 1'b1;
            end
         end
      end else begin
         for (int k = NUM_REQ; k >= 1; k--) begin
            rr_pos = IDX_BITS'((int'(ptr_q) - k + NUM_REQ) % NUM_REQ);
            if (cand[rr_pos]) begin
               win_idx   = rr_pos;
               win_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               gnt_d   = NUM_REQ'(1) << win_idx;
               idx_d   = win_idx;
               ptr_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         GRANT: begin
            if (release_evt) begin
`ifdef ARB_TIMEOUT_EN
               timeout_d = hold_expired & ~bus.done & bus.req[idx_q];
`endif
               if (win_found) begin
                  gnt_d = NUM_REQ'(1) << win_idx;
                  idx_d = win_idx;
                  ptr_d = win_idx;
`ifdef ARB_TIMEOUT_EN
                  cnt_d = '0;
`endif
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
               end
            end else begin
`ifdef ARB_TIMEOUT_EN
               cnt_d = cnt_q + TO_BITS'(1);
`endif
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
   assign bus.timeout   = timeout_q;
`endif

endmodule
